// File: rtl/gol_input_ctrl_pkg.sv
// Shared types and constants for the Game-of-Life edit/run controller.
`default_nettype none

package gol_input_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TOGGLE = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_RUN    = 3'd3,
    ST_STEP   = 3'd4
  } state_t;

  localparam logic WR_OP_TOGGLE = 1'b0;
  localparam logic WR_OP_CLEAR  = 1'b1;

  localparam int unsigned DEF_COLS = 16;
  localparam int unsigned DEF_ROWS = 16;

endpackage

`default_nettype wire

// File: rtl/gol_input_ctrl_tick_div.sv
// Generation prescaler: counts while enabled and pulses tick on the last count.
`default_nettype none

module gol_input_ctrl_tick_div #(
  parameter int unsigned GEN_TICKS = 25_000_000,
  parameter int unsigned TICK_W    = 25
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  logic [TICK_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == TICK_W'(GEN_TICKS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + TICK_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gol_input_ctrl.sv
// Edit/run controller: cursor, cell toggle/clear writes and paced generation stepping.
`default_nettype none

module gol_input_ctrl
  import gol_input_ctrl_pkg::*;
#(
  parameter int unsigned COLS      = DEF_COLS,
  parameter int unsigned ROWS      = DEF_ROWS,
  parameter int unsigned COL_W     = 4,
  parameter int unsigned ROW_W     = 4,
  parameter int unsigned GEN_TICKS = 25_000_000,
  parameter int unsigned TICK_W    = 25
) (
  input  logic             clk_50MHz_i,
  input  logic             rst_async_la_i,
  input  logic             up_os_i,
  input  logic             down_os_i,
  input  logic             left_os_i,
  input  logic             right_os_i,
  input  logic             toggle_os_i,
  input  logic             run_os_i,
  input  logic             clear_sw_i,
  input  logic             wr_ack_i,
  input  logic             step_done_i,
  output logic [COL_W-1:0] cur_x_o,
  output logic [ROW_W-1:0] cur_y_o,
  output logic             wr_req_o,
  output logic [COL_W-1:0] wr_x_o,
  output logic [ROW_W-1:0] wr_y_o,
  output logic             wr_op_o,
  output logic             step_req_o,
  output logic             running_o,
  output logic             busy_o
);

  state_t           state_q, state_d;
  logic [COL_W-1:0] cur_x_q, cur_x_d;
  logic [ROW_W-1:0] cur_y_q, cur_y_d;
  logic [COL_W-1:0] wr_x_q, wr_x_d;
  logic [ROW_W-1:0] wr_y_q, wr_y_d;
  logic             clear_sw_q;
  logic             pend_pause_q, pend_pause_d;
  logic             pend_clear_q, pend_clear_d;

  logic                   clear_edge;
  logic                   tick;
  logic                   addr_last;
  logic [ROW_W+COL_W-1:0] addr_next;

  assign clear_edge = clear_sw_i & ~clear_sw_q;
  assign addr_last  = (wr_x_q == COL_W'(COLS - 1)) && (wr_y_q == ROW_W'(ROWS - 1));
  assign addr_next  = {wr_y_q, wr_x_q} + (ROW_W + COL_W)'(1);

  // Prescaler is held at zero outside RUN, so every entry into RUN starts a full period.
  gol_input_ctrl_tick_div #(
    .GEN_TICKS (GEN_TICKS),
    .TICK_W    (TICK_W)
  ) u_tick_div (
    .clk_i   (clk_50MHz_i),
    .rst_n_i (rst_async_la_i),
    .en_i    (state_q == ST_RUN),
    .clr_i   (state_q != ST_RUN),
    .tick_o  (tick)
  );

  always_comb begin
    state_d      = state_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    wr_x_d       = wr_x_q;
    wr_y_d       = wr_y_q;
    pend_pause_d = pend_pause_q;
    pend_clear_d = pend_clear_q;

    unique case (state_q)
      ST_IDLE: begin
        if (clear_edge) begin
          state_d = ST_CLEAR;
          wr_x_d  = '0;
          wr_y_d  = '0;
        end else if (run_os_i) begin
          state_d = ST_RUN;
        end else if (toggle_os_i) begin
          state_d = ST_TOGGLE;
          wr_x_d  = cur_x_q;
          wr_y_d  = cur_y_q;
        end else begin
          if (right_os_i && !left_os_i) cur_x_d = cur_x_q + COL_W'(1);
          else if (left_os_i && !right_os_i) cur_x_d = cur_x_q - COL_W'(1);
          if (down_os_i && !up_os_i) cur_y_d = cur_y_q + ROW_W'(1);
          else if (up_os_i && !down_os_i) cur_y_d = cur_y_q - ROW_W'(1);
        end
      end
      ST_TOGGLE: begin
        if (wr_ack_i) state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        if (wr_ack_i) begin
          {wr_y_d, wr_x_d} = addr_next;
          if (addr_last) state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (clear_edge) begin
          state_d = ST_CLEAR;
          wr_x_d  = '0;
          wr_y_d  = '0;
        end else if (run_os_i) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        // Events coinciding with step_done are dropped; only earlier ones were latched.
        if (step_done_i) begin
          pend_pause_d = 1'b0;
          pend_clear_d = 1'b0;
          if (pend_clear_q) begin
            state_d = ST_CLEAR;
            wr_x_d  = '0;
            wr_y_d  = '0;
          end else if (pend_pause_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          if (clear_edge) pend_clear_d = 1'b1;
          if (run_os_i) pend_pause_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      state_q      <= ST_IDLE;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      wr_x_q       <= '0;
      wr_y_q       <= '0;
      clear_sw_q   <= 1'b0;
      pend_pause_q <= 1'b0;
      pend_clear_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      wr_x_q       <= wr_x_d;
      wr_y_q       <= wr_y_d;
      clear_sw_q   <= clear_sw_i;
      pend_pause_q <= pend_pause_d;
      pend_clear_q <= pend_clear_d;
    end
  end

  assign cur_x_o    = cur_x_q;
  assign cur_y_o    = cur_y_q;
  assign wr_x_o     = wr_x_q;
  assign wr_y_o     = wr_y_q;
  assign wr_req_o   = (state_q == ST_TOGGLE) || (state_q == ST_CLEAR);
  assign wr_op_o    = (state_q == ST_CLEAR) ? WR_OP_CLEAR : WR_OP_TOGGLE;
  assign step_req_o = (state_q == ST_STEP);
  assign running_o  = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign busy_o     = (state_q == ST_TOGGLE) || (state_q == ST_CLEAR) || (state_q == ST_STEP);

endmodule

`default_nettype wire
